// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// register-index width and the operand-match helper.
package hazard_ctrl_pkg;

    localparam int REG_W    = 5;
    localparam int FLUSH_W  = 4;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_FLUSH    = 2'd2
    } hz_state_t;

    function automatic logic srcMatch(
        input logic             used,
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] dst
    );
        return used && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of hazard sources from the pipeline and the control/counter outputs
// returned to it; the pipeline side is master, the controller is slave.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
) ();
    import hazard_ctrl_pkg::*;

    logic             icache_stall;
    logic             dcache_stall;
    logic             x_redirect;
    logic             x_load;
    logic [REG_W-1:0] x_rd;
    logic [REG_W-1:0] i_rs1;
    logic [REG_W-1:0] i_rs2;
    logic             i_rs1_used;
    logic             i_rs2_used;

    logic             stall;
    logic             flush_i;
    logic             load_bubble;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output icache_stall, dcache_stall, x_redirect, x_load, x_rd,
               i_rs1, i_rs2, i_rs1_used, i_rs2_used,
        input  stall, flush_i, load_bubble, state_o, stall_cnt, flush_cnt
    );

    modport slave (
        input  icache_stall, dcache_stall, x_redirect, x_load, x_rd,
               i_rs1, i_rs2, i_rs1_used, i_rs2_used,
        output stall, flush_i, load_bubble, state_o, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use compare: the I instruction reads the register the
// load in X is about to write. x0 never creates a dependency.
module load_use_detect
    import hazard_ctrl_pkg::*;
(
    input  logic             i_xLoad,
    input  logic [REG_W-1:0] i_xRd,
    input  logic [REG_W-1:0] i_rs1,
    input  logic [REG_W-1:0] i_rs2,
    input  logic             i_rs1Used,
    input  logic             i_rs2Used,
    output logic             o_hazard
);

    logic w_rdNonZero;
    logic w_srcHit;

    assign w_rdNonZero = (i_xRd != '0);
    assign w_srcHit    = srcMatch(i_rs1Used, i_rs1, i_xRd) |
                         srcMatch(i_rs2Used, i_rs2, i_xRd);
    assign o_hazard    = i_xLoad & w_rdNonZero & w_srcHit;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory stalls, redirect flush sequencing,
// load-use bubbles and saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);

    localparam logic [FLUSH_W-1:0] FLUSH_RELOAD = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam bit                 MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    hz_state_t          r_state;
    hz_state_t          w_stateNext;
    logic [FLUSH_W-1:0] r_flushLeft;
    logic [FLUSH_W-1:0] w_flushLeftNext;
    logic [CNT_W-1:0]   r_stallCnt;
    logic [CNT_W-1:0]   r_flushEvtCnt;

    logic w_stall;
    logic w_hazard;
    logic w_redirectAccept;

    assign w_stall = hz.icache_stall | hz.dcache_stall;

    load_use_detect u_loadUse (
        .i_xLoad   (hz.x_load),
        .i_xRd     (hz.x_rd),
        .i_rs1     (hz.i_rs1),
        .i_rs2     (hz.i_rs2),
        .i_rs1Used (hz.i_rs1_used),
        .i_rs2Used (hz.i_rs2_used),
        .o_hazard  (w_hazard)
    );

    always_ff @(posedge clk) begin
        r_state     <= w_stateNext;
        r_flushLeft <= w_flushLeftNext;
    end

    // MEM_WAIT resolves exactly like RUN once the stall drops, since X is
    // held and a pending redirect is still visible on x_redirect.
    always_comb begin
        w_stateNext      = r_state;
        w_flushLeftNext  = r_flushLeft;
        w_redirectAccept = 1'b0;
        if (reset) begin
            w_stateNext     = HZ_RUN;
            w_flushLeftNext = '0;
        end else begin
            case (r_state)
                HZ_RUN, HZ_MEM_WAIT: begin
                    if (w_stall) begin
                        w_stateNext = HZ_MEM_WAIT;
                    end else if (hz.x_redirect) begin
                        w_redirectAccept = 1'b1;
                        if (MULTI_FLUSH) begin
                            w_stateNext     = HZ_FLUSH;
                            w_flushLeftNext = FLUSH_RELOAD;
                        end else begin
                            w_stateNext = HZ_RUN;
                        end
                    end else begin
                        w_stateNext = HZ_RUN;
                    end
                end
                HZ_FLUSH: begin
                    if (!w_stall) begin
                        if (r_flushLeft <= FLUSH_W'(1)) begin
                            w_stateNext     = HZ_RUN;
                            w_flushLeftNext = '0;
                        end else begin
                            w_flushLeftNext = r_flushLeft - FLUSH_W'(1);
                        end
                    end
                end
                default: begin
                    w_stateNext     = HZ_RUN;
                    w_flushLeftNext = '0;
                end
            endcase
        end
    end

    always_comb begin
        hz.stall       = 1'b0;
        hz.flush_i     = 1'b0;
        hz.load_bubble = 1'b0;
        if (reset) begin
            hz.flush_i = 1'b1;
        end else begin
            hz.stall = w_stall;
            case (r_state)
                HZ_RUN, HZ_MEM_WAIT: begin
                    if (!w_stall) begin
                        if (hz.x_redirect) begin
                            hz.flush_i = 1'b1;
                        end else begin
                            hz.load_bubble = w_hazard;
                        end
                    end
                end
                HZ_FLUSH: hz.flush_i = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCnt    <= '0;
            r_flushEvtCnt <= '0;
        end else begin
            if (w_stall && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
            if (w_redirectAccept && (r_flushEvtCnt != '1)) begin
                r_flushEvtCnt <= r_flushEvtCnt + CNT_W'(1);
            end
        end
    end

    assign hz.state_o   = r_state;
    assign hz.stall_cnt = reset ? '0 : r_stallCnt;
    assign hz.flush_cnt = reset ? '0 : r_flushEvtCnt;

endmodule
